// File: rtl/inst_fetch_pkg.sv
// Shared defines for the instruction fetch unit: bus widths, the NOP word,
// FSM state encodings and small state-decoding helpers.
package inst_fetch_pkg;

  localparam int ADDR_W   = 32;
  localparam int INST_W   = 32;
  localparam int BYTE_W   = 8;
  localparam int STALL_W  = 6;
  localparam int STALL_IF = 1;

  localparam logic [INST_W-1:0] INST_NOP = 32'h00000013;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_RD2  = 3'd3,
    S_RD3  = 3'd4,
    S_WAIT = 3'd5,
    S_DONE = 3'd6
  } fetch_state_e;

  // Byte offset from the fetch address requested in a read state.
  function automatic logic [1:0] rd_offset(input fetch_state_e s);
    case (s)
      S_RD1:   return 2'd1;
      S_RD2:   return 2'd2;
      S_RD3:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Read state that follows a granted request.
  function automatic fetch_state_e next_rd(input fetch_state_e s);
    case (s)
      S_RD0:   return S_RD1;
      S_RD1:   return S_RD2;
      S_RD2:   return S_RD3;
      default: return S_WAIT;
    endcase
  endfunction

  // States in which the fetch owns the pipeline and PC/IF must stall.
  function automatic logic is_busy(input fetch_state_e s);
    return (s == S_RD0) || (s == S_RD1) || (s == S_RD2) ||
           (s == S_RD3) || (s == S_WAIT);
  endfunction

endpackage

// File: rtl/inst_fetch_cache.sv
// Direct-mapped instruction cache used by inst_fetch when ICACHE_EN is defined.
// Combinational read port, single-entry fill port, valid bits cleared by reset.
// The tag keeps every address bit outside the index, including pc[1:0], so a
// misaligned fetch never aliases with the aligned word at the same index.
module inst_cache
  import inst_fetch_pkg::*;
#(
  parameter int LINES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_hit_o,
  output logic [INST_W-1:0] rd_data_o,
  input  logic              fill_en_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [INST_W-1:0] fill_data_i
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [INST_W-1:0] data_q [LINES];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] fill_idx;

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return a[IDX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:IDX_W+2], a[1:0]};
  endfunction

  assign rd_idx    = idx_of(rd_addr_i);
  assign fill_idx  = idx_of(fill_addr_i);
  assign rd_hit_o  = valid_q[rd_idx] && (tag_q[rd_idx] == tag_of(rd_addr_i));
  assign rd_data_o = data_q[rd_idx];

  // Valid bits: cleared by reset, set by a fill.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data storage written on a fill.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[fill_idx]  <= tag_of(fill_addr_i);
      data_q[fill_idx] <= fill_data_i;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: assembles a 32-bit instruction from four byte reads
// on a shared, arbitrated memory port. Optional direct-mapped cache is built
// when the macro ICACHE_EN is defined; the default build has no cache.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int ICACHE_LINES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic               right_one_i,
  input  logic               branch_flag_i,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               mem_grant_i,
  output logic               mem_req_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  input  logic [BYTE_W-1:0]  mem_rdata_i,
  output logic [INST_W-1:0]  inst_o,
  output logic [ADDR_W-1:0]  inst_pc_o,
  output logic               inst_valid_o,
  output logic               stallreq_o
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [23:0]       buf_q, buf_d;
  logic              pend_q, pend_d;
  logic [1:0]        pend_idx_q, pend_idx_d;
  logic              stallreq_q;
  logic              hold_if;
  logic              fill_en;
  logic              hit;
  logic [INST_W-1:0] hit_data;
  logic [6:0]        unused_cfg;
  logic              unused_ok;

  assign hold_if    = stall_i[STALL_IF];
  assign unused_cfg = 7'(ICACHE_LINES);
  assign unused_ok  = ^{stall_i[5:2], stall_i[0], right_one_i, unused_cfg};

`ifdef ICACHE_EN
  inst_cache #(
    .LINES(ICACHE_LINES)
  ) u_cache (
    .clk         (clk),
    .rst         (rst),
    .rd_addr_i   (pc_i),
    .rd_hit_o    (hit),
    .rd_data_o   (hit_data),
    .fill_en_i   (fill_en),
    .fill_addr_i (inst_pc_q),
    .fill_data_i ({mem_rdata_i, buf_q})
  );
`else
  logic unused_fill;
  assign hit         = 1'b0;
  assign hit_data    = INST_NOP;
  assign unused_fill = fill_en;
`endif

  // Next-state, byte assembly and memory request decode.
  always_comb begin
    state_d    = state_q;
    inst_pc_d  = inst_pc_q;
    inst_d     = inst_q;
    buf_d      = buf_q;
    pend_d     = 1'b0;
    pend_idx_d = pend_idx_q;
    fill_en    = 1'b0;
    mem_req_o  = 1'b0;
    mem_addr_o = '0;

    // The byte requested in the previous granted cycle is on the bus now.
    if (pend_q) begin
      buf_d[{pend_idx_q, 3'b000} +: BYTE_W] = mem_rdata_i;
    end

    case (state_q)
      S_IDLE: begin
        if (!hold_if && !branch_flag_i) begin
          inst_pc_d = pc_i;
          if (hit) begin
            inst_d  = hit_data;
            state_d = S_DONE;
          end else begin
            state_d = S_RD0;
          end
        end
      end
      S_RD0, S_RD1, S_RD2, S_RD3: begin
        mem_req_o  = !branch_flag_i;
        mem_addr_o = inst_pc_q + ADDR_W'(rd_offset(state_q));
        if (mem_grant_i && !branch_flag_i) begin
          pend_d     = (state_q != S_RD3);
          pend_idx_d = rd_offset(state_q);
          state_d    = next_rd(state_q);
        end
      end
      S_WAIT: begin
        inst_d  = {mem_rdata_i, buf_q};
        fill_en = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!hold_if) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A redirect aborts everything: no capture, no completion, no fill.
    if (branch_flag_i) begin
      state_d   = S_IDLE;
      inst_pc_d = inst_pc_q;
      inst_d    = inst_q;
      fill_en   = 1'b0;
    end
  end

  // Control and architecturally visible state, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      inst_pc_q  <= '0;
      inst_q     <= INST_NOP;
      stallreq_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inst_pc_q  <= inst_pc_d;
      inst_q     <= inst_d;
      stallreq_q <= is_busy(state_d);
      pend_q     <= pend_d;
    end
  end

  // Byte assembly buffer; always fully rewritten before it is consumed.
  always_ff @(posedge clk) begin
    buf_q      <= buf_d;
    pend_idx_q <= pend_idx_d;
  end

  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = (state_q == S_DONE);
  assign stallreq_o   = stallreq_q;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        right_one_i;
  logic        branch_flag_i;
  logic [5:0]  stall_i;
  logic        mem_grant_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        stallreq_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_pc = 32'h0;

  inst_fetch #(.ICACHE_LINES(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .right_one_i   (right_one_i),
    .branch_flag_i (branch_flag_i),
    .stall_i       (stall_i),
    .mem_grant_i   (mem_grant_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_rdata_i   (mem_rdata_i),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_valid_o  (inst_valid_o),
    .stallreq_o    (stallreq_o)
  );

  always #5 clk = ~clk;

  // Byte-addressed memory contents: a fixed program word at 0x1000, a hash elsewhere.
  function automatic logic [7:0] memb(input logic [31:0] a);
    case (a)
      32'h00001000: return 8'h13;
      32'h00001001: return 8'h05;
      32'h00001002: return 8'h10;
      32'h00001003: return 8'h00;
      default:      return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] p);
    return {memb(p + 32'd3), memb(p + 32'd2), memb(p + 32'd1), memb(p)};
  endfunction

  // Memory responder: data for a granted request appears in the following cycle.
  logic        rsp_fire;
  logic [31:0] rsp_addr;
  always begin
    @(negedge clk);
    #4;
    rsp_fire = mem_req_o && mem_grant_i;
    rsp_addr = mem_addr_o;
    @(posedge clk);
    #1;
    mem_rdata_i = rsp_fire ? memb(rsp_addr) : 8'($urandom);
  end

  task automatic test_reset();
    rst = 1'b0;
    branch_flag_i = 1'b0;
    stall_i = 6'b000010;
    @(negedge clk);
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req_o); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr_o); end
    checks++; if (inst_o !== 32'h00000013) begin errors++; $display("FAIL reset_inst got %h want 00000013", inst_o); end
    checks++; if (inst_pc_o !== 32'h0) begin errors++; $display("FAIL reset_inst_pc got %h want 0", inst_pc_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", inst_valid_o); end
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stallreq got %b want 0", stallreq_o); end
    rst = 1'b1;
    last_pc = 32'h0;
  endtask

  // One complete memory-path fetch. mode 0: grant always; 1: grant withheld
  // three cycles while byte 2 is requested; 2: random grant.
  task automatic run_fetch(input logic [31:0] p, input int mode, input string name);
    logic [31:0] exp_inst;
    int          granted, waits, cyc, low_left, nhold;
    bit          done;
    logic        g;
    exp_inst = word_at(p);
    granted = 0; waits = 0; cyc = 0; low_left = 3; done = 1'b0;
    @(negedge clk);
    pc_i = p;
    branch_flag_i = 1'b0;
    stall_i = 6'($urandom) & 6'b111101;
    mem_grant_i = 1'b1;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (inst_valid_o) begin
        done = 1'b1;
        stall_i[1] = 1'b1;
        checks++; if (cyc != 6 + waits) begin errors++; $display("FAIL %s latency got %0d want %0d", name, cyc, 6 + waits); end
        checks++; if (inst_o !== exp_inst) begin errors++; $display("FAIL %s inst got %h want %h", name, inst_o, exp_inst); end
        checks++; if (inst_pc_o !== p) begin errors++; $display("FAIL %s inst_pc got %h want %h", name, inst_pc_o, p); end
        checks++; if (granted != 4) begin errors++; $display("FAIL %s granted_reads got %0d want 4", name, granted); end
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL %s done_stallreq got %b want 0", name, stallreq_o); end
      end else begin
        checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL %s busy_stallreq cyc %0d got %b want 1", name, cyc, stallreq_o); end
        if (mem_req_o) begin
          checks++;
          if (mem_addr_o !== p + 32'(granted)) begin
            errors++; $display("FAIL %s mem_addr cyc %0d got %h want %h", name, cyc, mem_addr_o, p + 32'(granted));
          end
          case (mode)
            0:       g = 1'b1;
            1:       g = !(granted == 2 && low_left > 0);
            default: g = ($urandom_range(0, 3) != 0);
          endcase
          if (mode == 1 && !g) low_left--;
          mem_grant_i = g;
          if (g) granted++; else waits++;
        end else begin
          mem_grant_i = 1'($urandom);
        end
      end
    end
    if (!done) begin
      errors++; $display("FAIL %s timeout got no valid want valid within 60 cycles", name);
    end else begin
      last_pc = p;
      nhold = $urandom_range(1, 3);
      for (int i = 0; i < nhold; i++) begin
        mem_grant_i = 1'($urandom);
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b1 || inst_o !== exp_inst) begin
          errors++; $display("FAIL %s hold got valid %b inst %h want 1 %h", name, inst_valid_o, inst_o, exp_inst);
        end
      end
      stall_i[1] = 1'b0;
      @(negedge clk);
      checks++; if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
        errors++; $display("FAIL %s release got valid %b req %b want 0 0", name, inst_valid_o, mem_req_o);
      end
      stall_i[1] = 1'b1;
    end
  endtask

  task automatic test_basic();
    run_fetch(32'h00001000, 0, "basic");
    checks++; if (word_at(32'h00001000) !== 32'h00100513) begin
      errors++; $display("FAIL basic_table got %h want 00100513", word_at(32'h00001000));
    end
  endtask

  task automatic test_grant_gap();
    run_fetch(32'h00001100, 1, "grant_gap");
  endtask

  task automatic test_wrap();
    run_fetch(32'hFFFFFFFE, 2, "wrap");
  endtask

  task automatic test_branch_abort();
    logic [31:0] p, tgt;
    p   = {16'h3000, 16'($urandom)};
    tgt = {16'h4000, 16'($urandom)};
    @(negedge clk);
    pc_i = p; stall_i[1] = 1'b0; mem_grant_i = 1'b1; branch_flag_i = 1'b0;
    @(negedge clk);
    stall_i[1] = 1'b1;
    @(negedge clk);
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== p + 32'd1) begin
      errors++; $display("FAIL abort_rd1 got req %b addr %h want 1 %h", mem_req_o, mem_addr_o, p + 32'd1);
    end
    branch_flag_i = 1'b1; mem_grant_i = 1'b1; pc_i = tgt;
    @(negedge clk);
    branch_flag_i = 1'b0;
    checks++; if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || stallreq_o !== 1'b0) begin
      errors++; $display("FAIL abort_idle got req %b valid %b stallreq %b want 0 0 0", mem_req_o, inst_valid_o, stallreq_o);
    end
    run_fetch(tgt, 0, "after_abort");
  endtask

  task automatic test_branch_idle();
    @(negedge clk);
    pc_i = 32'h77770000; stall_i[1] = 1'b0; branch_flag_i = 1'b1;
    @(negedge clk);
    checks++; if (inst_pc_o !== last_pc || mem_req_o !== 1'b0 || stallreq_o !== 1'b0) begin
      errors++; $display("FAIL idle_branch got pc %h req %b stallreq %b want %h 0 0", inst_pc_o, mem_req_o, stallreq_o, last_pc);
    end
    branch_flag_i = 1'b0; stall_i[1] = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) begin
      run_fetch($urandom, $urandom_range(0, 2), "random");
    end
  endtask

  task automatic test_reset_midfetch();
    logic [31:0] p;
    bit          found;
    p = {16'h5000, 16'($urandom)};
    found = 1'b0;
    @(negedge clk);
    pc_i = p; stall_i[1] = 1'b0; mem_grant_i = 1'b1; branch_flag_i = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      stall_i[1] = 1'b1;
      if (mem_req_o === 1'b1 && mem_addr_o === p + 32'd3) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL midfetch_rd3 got no RD3 want RD3 within 10 cycles"); end
    test_reset();
    run_fetch({16'h6000, 16'($urandom)}, 2, "after_reset");
  endtask

`ifdef ICACHE_EN
  task automatic test_cache_hit();
    run_fetch(32'h00002000, 0, "cache_fill");
    @(negedge clk);
    pc_i = 32'h00002000; stall_i[1] = 1'b0; mem_grant_i = 1'b1;
    @(negedge clk);
    stall_i[1] = 1'b1;
    checks++; if (inst_valid_o !== 1'b1 || mem_req_o !== 1'b0 || stallreq_o !== 1'b0) begin
      errors++; $display("FAIL cache_hit got valid %b req %b stallreq %b want 1 0 0", inst_valid_o, mem_req_o, stallreq_o);
    end
    checks++; if (inst_o !== word_at(32'h00002000) || inst_pc_o !== 32'h00002000) begin
      errors++; $display("FAIL cache_data got %h @%h want %h @00002000", inst_o, inst_pc_o, word_at(32'h00002000));
    end
    stall_i[1] = 1'b0;
    @(negedge clk);
    stall_i[1] = 1'b1;
    last_pc = 32'h00002000;
  endtask
`endif

  initial begin
    rst = 1'b0; pc_i = 32'h0; right_one_i = 1'b0; branch_flag_i = 1'b0;
    stall_i = 6'b000010; mem_grant_i = 1'b0; mem_rdata_i = 8'h0;
    test_reset();
    test_basic();
    test_grant_gap();
    test_wrap();
    test_branch_abort();
    test_branch_idle();
    test_random();
    test_reset_midfetch();
`ifdef ICACHE_EN
    test_cache_hit();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: ICACHE_LINES, default 8, number of instruction-cache entries; power of two, 2..64.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 pc_i  in  32  fetch address from the PC register.
REQ-005 right_one_i  in  1  pc_i is the first address after a redirect.
REQ-006 branch_flag_i  in  1  redirect; abort any fetch in flight.
REQ-007 stall_i  in  6  pipeline stall vector; bit 1 holds the IF stage.
REQ-008 mem_grant_i  in  1  memory arbiter grants this port for the current cycle.
REQ-009 mem_req_o  out  1  byte read request.
REQ-010 mem_addr_o  out  32  byte read address.
REQ-011 mem_rdata_i  in  8  read data, valid one cycle after a granted request.
REQ-012 inst_o  out  32  fetched instruction word.
REQ-013 inst_pc_o  out  32  address of inst_o.
REQ-014 inst_valid_o  out  1  inst_o/inst_pc_o valid for the ID stage.
REQ-015 stallreq_o  out  1  registered request to stall PC and IF.

Function
REQ-016 The FSM SHALL use states IDLE, RD0, RD1, RD2, RD3, WAIT, DONE.
REQ-017 In IDLE with stall_i[1]=0 and branch_flag_i=0, the block SHALL capture pc_i into inst_pc_o and enter RD0.
REQ-018 RDk SHALL drive mem_req_o=1 and mem_addr_o=pc+k (mod 2^32); it SHALL advance only when mem_grant_i=1.
REQ-019 A byte SHALL be taken one cycle after its granted request; byte k SHALL be stored into inst_o[8k+7:8k] (little-endian).
REQ-020 WAIT SHALL take byte 3 with mem_req_o=0, then enter DONE.
REQ-021 With continuous grant, inst_valid_o SHALL rise exactly 6 cycles after the capture edge.
REQ-022 DONE SHALL hold inst_valid_o=1 and inst_o stable until stall_i[1]=0, then enter IDLE; inst_valid_o SHALL drop in that same cycle.
REQ-023 stallreq_o SHALL be 1 in RD0..WAIT and 0 in IDLE and DONE.
REQ-024 branch_flag_i=1 in any state SHALL force IDLE on the next edge, with mem_req_o=0, inst_valid_o=0 and no capture that cycle.
REQ-025 When branch_flag_i and a grant occur in the same cycle, the abort SHALL win and the returned byte SHALL be discarded.
REQ-026 pc_i[1:0] SHALL be used unmodified; misaligned addresses SHALL fetch four consecutive bytes.

Reset
REQ-027 rst=0 at a clock edge SHALL set state=IDLE, mem_req_o=0, mem_addr_o=0, inst_o=32'h00000013, inst_pc_o=0, inst_valid_o=0, stallreq_o=0, and all cache valid bits=0.
REQ-028 Reset mid-fetch SHALL discard partial bytes; the first fetch after release SHALL start from IDLE.

Configuration
REQ-029 With ICACHE_EN defined, a direct-mapped cache SHALL be built: index pc[log2(ICACHE_LINES)+1:2], remaining upper bits as tag.
REQ-030 ICACHE_EN: a hit at IDLE capture SHALL go directly to DONE (valid next edge) with no memory request and stallreq_o=0.
REQ-031 ICACHE_EN: every completed miss SHALL fill its entry in the WAIT->DONE edge; an aborted fetch SHALL NOT fill.
REQ-032 Without ICACHE_EN, there SHALL be no cache storage and every fetch SHALL use the memory path.

Structure
REQ-033 FSM state encodings, the NOP constant 32'h00000013 and bus widths SHALL live in the shared Defines package.
REQ-034 The cache SHALL be a sub-module inst_cache (read port, fill port, synchronous clear).

Verification
REQ-035 pc_i=0x1000, grant held 1, bytes 13,05,10,00 -> mem_addr_o 0x1000..0x1003; inst_o=0x00100513, inst_pc_o=0x1000; valid at cycle 6.
REQ-036 Grant low 3 cycles during RD2 -> mem_addr_o holds 0x1002; valid at cycle 9; inst_o correct.
REQ-037 branch_flag_i pulse in RD1 -> next cycle IDLE, mem_req_o=0; no inst_valid_o; the next capture takes pc_i=target.
REQ-038 pc_i=0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
REQ-039 ICACHE_EN: fetch 0x2000 twice -> second fetch has valid one edge after capture and mem_req_o stays 0.
REQ-040 rst=0 asserted in RD3 -> all outputs reach the REQ-027 values on the next edge; the next fetch reads four fresh bytes.
